// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width: cnt runs 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_full_adder.sv
// One-bit full adder built from two half-adder cells and an OR gate.
module half_add_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  logic s0, c0, c1;

  half_add_cell u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_add_cell u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  // The two half-adder carries can never both be set, so OR gives the majority.
  assign c = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB-first over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_c;

  bit_full_adder u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (bit_s),
    .c   (bit_c)
  );

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  // NOTE: every register here uses <= so all of them see pre-edge values,
  // which is what lets the shift, carry and count advance in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= {bit_s, acc[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          // sum/cout only move on the final bit so they hold the old result during RUN.
          if (cnt == LAST) begin
            sum   <= {bit_s, acc[WIDTH-1:1]};
            cout  <= bit_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial N-bit adder controller. It sequences a single one-bit full-adder cell, built from two half-adder cells and an OR gate, across WIDTH cycles to produce an N-bit sum and carry-out. A start/ready/done handshake connects it to the surrounding datapath. It trades latency for area wherever a wide parallel adder is not justified.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while ready=1.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- cin  in  1  carry-in; sampled on the accepting edge.
- ready  out  1  high when state=IDLE; combinational from state.
- busy  out  1  high when state=RUN; combinational from state.
- done  out  1  registered one-cycle completion pulse.
- sum  out  WIDTH  result; registered and held until the next completion.
- cout  out  1  carry-out; registered and held with sum.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a clock edge with start=1.
  - On that edge: opa<=a, opb<=b, carry<=cin, cnt<=0, acc<=0.
- RUN, each edge:
  - The bit cell computes s = opa[0]^opb[0]^carry and c = majority(opa[0], opb[0], carry).
  - Shift right: opa<=opa>>1, opb<=opb>>1, acc<={s, acc[WIDTH-1:1]}, carry<=c, cnt<=cnt+1.
- RUN -> DONE on the edge where cnt=WIDTH-1 (the last bit is processed on this edge).
  - On that edge: sum<={s, acc[WIDTH-1:1]}, cout<=c, done<=1.
- DONE -> IDLE unconditionally on the next edge; done<=0.
- start is ignored in RUN and DONE. No queuing; the requester must re-assert start once ready=1.
- The adder is modulo 2^WIDTH; overflow appears only on cout.
- sum and cout do not change during RUN; they keep the previous result.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, cnt=0, carry=0, opa/opb/acc=0.
- Reset mid-operation: the operation is abandoned, every register takes its reset value, and no done pulse is issued.
- Changes to a, b or cin after the accepting edge have no effect on the result.

## Timing
- Count start high in cycle 0, with the accepting edge at the end of cycle 0.
- busy is high in cycles 1..WIDTH.
- done, sum and cout are valid in cycle WIDTH+1.
- ready returns high in cycle WIDTH+2.
- Latency from start to done is WIDTH+1 cycles. Maximum throughput is one operation per WIDTH+2 cycles.
- Back-to-back: a start held high continuously is accepted again at the end of cycle WIDTH+2.
- The done pulse is exactly one cycle wide, regardless of start.
- Critical path: one full-adder cell plus the shift-register muxing; it is independent of WIDTH.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function cnt_w(WIDTH) = $clog2(WIDTH), used for the counter width.
- Sub-module bit_full_adder (a, b, cin -> s, c) contains two half-adder cell instances plus an OR gate. It is instantiated once.
- The controller contains the FSM, operand shift registers, carry flip-flop, counter and output registers. It has no other sub-modules.

## Test plan
All scenarios use WIDTH=8.
- Reset: rst_n=0 -> ready=1, busy=0, done=0, sum=0x00, cout=0 throughout; the FSM stays in IDLE.
- 0x5A+0x33, cin=0 -> done in cycle 9, sum=0x8D, cout=0; busy high in cycles 1..8.
- 0xFF+0x01, cin=0 -> sum=0x00, cout=1.
- 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulsed in cycle 4 of an operation, with different operands -> ignored; the first result is correct and only one done pulse occurs.
- rst_n pulsed low in cycle 5 of a 0x12+0x34 operation -> no done pulse, sum stays 0x00. A new request 0x12+0x34 then gives sum=0x46.
- start held high for 30 cycles with 0x01+0x01 -> done pulses in cycles 9, 19 and 29, each with sum=0x02.
